// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready accept, iterative shifter and shift-add multiplier
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       sh_op;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quick_res;
  logic             quick_c;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] prod_step;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign shamt     = B[SHW-1:0];
  assign sum       = {1'b0, A} + {1'b0, B};
  // The extra MSB of an unsigned (WIDTH+1)-bit difference is the borrow.
  assign diff      = {1'b0, A} - {1'b0, B};
  assign prod_step = mplier[0] ? (prod + mcand) : prod;

  always_comb begin
    quick_res = A;
    quick_c   = 1'b0;
    case (alu_op)
      OP_AND: quick_res = A & B;
      OP_OR:  quick_res = A | B;
      OP_ADD: begin
        quick_res = sum[WIDTH-1:0];
        quick_c   = sum[WIDTH];
      end
      OP_SUB: begin
        quick_res = diff[WIDTH-1:0];
        quick_c   = diff[WIDTH];
      end
      default: quick_res = A;
    endcase
  end

  always_comb begin
    case (sh_op)
      2'b00:   acc_step = {acc[WIDTH-2:0], 1'b0};
      2'b01:   acc_step = {1'b0, acc[WIDTH-1:1]};
      default: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh_op     <= 2'b00;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (alu_op == OP_MUL) begin
              mcand  <= A;
              mplier <= B;
              prod   <= '0;
              cnt    <= CNT_FULL;
              state  <= ST_MUL;
            end else if (alu_op[2] && (shamt != '0)) begin
              acc   <= A;
              cnt   <= {1'b0, shamt};
              sh_op <= alu_op[1:0];
              state <= ST_SHIFT;
            end else begin
              result    <= quick_res;
              zero      <= (quick_res == '0);
              carry     <= quick_c;
              out_valid <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result    <= acc_step;
            zero      <= (acc_step == '0);
            carry     <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_MUL: begin
          prod   <= prod_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_ONE;
          // Fixed WIDTH iterations: no early exit on a zero multiplier.
          if (cnt == CNT_ONE) begin
            result    <= prod_step;
            zero      <= (prod_step == '0);
            carry     <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
